wb_sched: RTL and testbench
===========================

Name: wb_sched

Overview:
Writeback scheduler for the register-file write port. It owns the 4-bit select of the writeback mux, the destination register address and the register write enable. Two requesters share the single write port: the control unit (ALU, Hi, Lo, constants, shifter, upper-immediate results) and the load path (MDR data). After reset it also performs a one-time stack-pointer initialisation write of the constant 227.

Parameters:
REG_AW, 5, register address width
SEL_W, 4, writeback mux select width
INIT_EN, 1, 1 = perform the stack-pointer init write after reset
INIT_REG, 29, destination register of the init write
STARVE_MAX, 2, consecutive control-unit losses before the control unit is forced to win

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  reset, asynchronous, active-low; one clock domain only
cu_valid  in  1  control-unit write request
cu_ready  out  1  control-unit request accepted when valid && ready
cu_sel  in  SEL_W  requested mux source code
cu_dst  in  REG_AW  destination register
ld_valid  in  1  load writeback request (source is implicitly MDR, code 0001)
ld_ready  out  1  load request accepted when valid && ready
ld_dst  in  REG_AW  load destination register
wb_sel  out  SEL_W  writeback mux select, registered
wb_dst  out  REG_AW  register-file write address, registered
wb_we  out  1  register-file write enable, registered
init_done  out  1  high once the init phase is complete
sel_err  out  1  one-cycle pulse on an illegal cu_sel
pend_cnt  out  2  number of occupied holding buffers (0..2)

Behaviour:
- Reset (async, reset_n=0):
  - wb_sel=0101 (zero constant); wb_dst=0; wb_we=0; init_done=0; sel_err=0.
  - Both buffers are empty and the state is INIT.
  - Reset mid-operation discards the buffered requests, and the INIT phase runs again.
- FSM states are INIT and RUN.
- INIT state:
  - cu_ready=0 and ld_ready=0.
  - If INIT_EN=1, the first clock edge after reset release registers wb_sel=0100, wb_dst=INIT_REG, wb_we=1 for exactly one cycle. On that same edge init_done goes to 1 and the state goes to RUN.
  - If INIT_EN=0, the first edge goes to RUN with wb_we=0.
- Holding buffers:
  - There is one entry per requester, {sel, dst}. The load buffer sel is fixed at 0001.
  - ready = buffer empty OR buffer issued this cycle. This allows 1 request/cycle per uncontested requester.
- Issue (RUN):
  - At most one write per cycle. Outputs are registered on the edge after the decision.
  - Latency: a request accepted on edge E produces wb_we=1 in the cycle after edge E+1 at the earliest.
- Priority:
  - The load buffer wins by default (older instruction).
  - A starvation counter counts consecutive cycles in which the control-unit buffer was occupied but lost. When the counter equals STARVE_MAX, the control unit wins and the counter clears.
  - The counter also clears whenever the control unit issues.
- Idle cycles: wb_we=0, and wb_sel/wb_dst hold their last value. The downstream mux is sensitive only to the select, so it must not glitch.
- Destination 0: the request is issued normally (slot consumed, wb_sel/wb_dst updated) but wb_we=0.
- Illegal select:
  - Legal cu_sel values are 0000..1000 except 0001, which is reserved for the load path.
  - Any other cu_sel completes the handshake, pulses sel_err for one cycle and is dropped; it is not buffered.
- Same destination in both buffers: the load issues first and the control unit second, so the control-unit value is the final register content.
- pend_cnt is the registered count of occupied buffers.

Decomposition:
- Shared package:
  - Writeback source codes: WB_ALU=0000, WB_MDR=0001, WB_HI=0010, WB_LO=0011, WB_K227=0100, WB_ZERO=0101, WB_ONE=0110, WB_SHIFT=0111, WB_LUI=1000.
  - The FSM state encoding.
  - The SP_INIT_REG constant.
- Sub-module: wb_hold_buf, a one-entry valid/ready holding register, instantiated twice.

Test Plan:
- Reset release with INIT_EN=1 -> exactly one cycle of wb_we=1, wb_sel=0100, wb_dst=29. init_done=1 afterwards; ready signals low during INIT.
- Single control-unit request sel=0010, dst=8 -> wb_we=1, wb_sel=0010, wb_dst=8 two edges after acceptance. wb_sel then holds 0010 while idle.
- Load and control-unit requests accepted on the same edge, both dst=5 -> load write (sel 0001) first, control-unit write next cycle. pend_cnt goes 2 -> 1 -> 0.
- Continuous load requests with a pending control-unit request -> the control unit issues after exactly STARVE_MAX=2 load writes.
- cu_sel=1011 or 0001 -> handshake completes, sel_err pulses once, no wb_we. A request with dst=0 -> slot issued, wb_we=0.
- reset_n asserted with both buffers full -> outputs return to reset values immediately. After release, the INIT write repeats and no stale request issues.

Source files
------------

// File: rtl/wb_sched_pkg.sv
// Shared definitions for the register-file writeback scheduler:
// writeback mux source codes, FSM state encoding and the stack-pointer init target.
package wb_sched_pkg;

  typedef enum logic [3:0] {
    WB_ALU   = 4'b0000,
    WB_MDR   = 4'b0001,
    WB_HI    = 4'b0010,
    WB_LO    = 4'b0011,
    WB_K227  = 4'b0100,
    WB_ZERO  = 4'b0101,
    WB_ONE   = 4'b0110,
    WB_SHIFT = 4'b0111,
    WB_LUI   = 4'b1000
  } wb_src_e;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int SP_INIT_REG = 29;

  // MDR (0001) belongs to the load path, so the control unit may not request it.
  function automatic logic cu_sel_legal(input logic [3:0] sel);
    return (sel <= 4'(WB_LUI)) && (sel != 4'(WB_MDR));
  endfunction

endpackage

// File: rtl/wb_sched_if.sv
// Request and writeback-port bundle between the two requesters and the scheduler.
interface wb_sched_if #(
  parameter int REG_AW = 5,
  parameter int SEL_W  = 4
);
  logic              cu_valid;
  logic              cu_ready;
  logic [SEL_W-1:0]  cu_sel;
  logic [REG_AW-1:0] cu_dst;
  logic              ld_valid;
  logic              ld_ready;
  logic [REG_AW-1:0] ld_dst;
  logic [SEL_W-1:0]  wb_sel;
  logic [REG_AW-1:0] wb_dst;
  logic              wb_we;
  logic              init_done;
  logic              sel_err;
  logic [1:0]        pend_cnt;

  modport master (
    output cu_valid, cu_sel, cu_dst, ld_valid, ld_dst,
    input  cu_ready, ld_ready, wb_sel, wb_dst, wb_we, init_done, sel_err, pend_cnt
  );

  modport slave (
    input  cu_valid, cu_sel, cu_dst, ld_valid, ld_dst,
    output cu_ready, ld_ready, wb_sel, wb_dst, wb_we, init_done, sel_err, pend_cnt
  );
endinterface

// File: rtl/wb_hold_buf.sv
// One-entry holding register; it can be refilled in the same cycle its entry issues.
module wb_hold_buf #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         issue,
  output logic         ready,
  output logic         valid,
  output logic [W-1:0] dout
);
  logic         valid_r;
  logic [W-1:0] data_r;

  assign ready = !valid_r || issue;
  assign valid = valid_r;
  assign dout  = data_r;

  // Entry capture on push, release on issue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_r <= 1'b0;
      data_r  <= '0;
    end else if (push) begin
      valid_r <= 1'b1;
      data_r  <= din;
    end else if (issue) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end
endmodule

// File: rtl/wb_sched.sv
// Writeback scheduler: arbitrates the control unit and load path onto the single
// register-file write port, after a one-time stack-pointer init write.
module wb_sched
  import wb_sched_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int SEL_W      = 4,
  parameter bit INIT_EN    = 1'b1,
  parameter int INIT_REG   = SP_INIT_REG,
  parameter int STARVE_MAX = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  wb_sched_if.slave  bus
);
  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int BW = SEL_W + REG_AW;

  state_e            state_r, state_nxt;
  logic              run_s;
  logic              cu_push_s, ld_push_s, cu_rdy_s, ld_rdy_s;
  logic              cu_ready_s, ld_ready_s, cu_v_s, ld_v_s;
  logic [BW-1:0]     cu_q_s, ld_q_s;
  logic              cu_pick_s, ld_pick_s;
  logic [CW-1:0]     starve_r, starve_nxt;
  logic [SEL_W-1:0]  wb_sel_r;
  logic [REG_AW-1:0] wb_dst_r;
  logic              wb_we_r, init_done_r, sel_err_r;
  logic [1:0]        pend_cnt_r;
  logic              cu_nxt_s, ld_nxt_s;

  assign cu_ready_s = run_s && cu_rdy_s;
  assign ld_ready_s = run_s && ld_rdy_s;
  // Illegal selects still handshake but never enter the buffer.
  assign cu_push_s  = bus.cu_valid && cu_ready_s && cu_sel_legal(bus.cu_sel);
  assign ld_push_s  = bus.ld_valid && ld_ready_s;
  assign cu_nxt_s   = cu_push_s || (cu_v_s && !cu_pick_s);
  assign ld_nxt_s   = ld_push_s || (ld_v_s && !ld_pick_s);

  wb_hold_buf #(.W(BW)) u_cu_buf (
    .clk(clk), .reset_n(reset_n), .push(cu_push_s), .din({bus.cu_sel, bus.cu_dst}),
    .issue(cu_pick_s), .ready(cu_rdy_s), .valid(cu_v_s), .dout(cu_q_s)
  );

  wb_hold_buf #(.W(BW)) u_ld_buf (
    .clk(clk), .reset_n(reset_n), .push(ld_push_s), .din({SEL_W'(WB_MDR), bus.ld_dst}),
    .issue(ld_pick_s), .ready(ld_rdy_s), .valid(ld_v_s), .dout(ld_q_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next state and issue arbitration; loads win unless the control unit is starved.
  always_comb begin
    state_nxt  = state_r;
    run_s      = 1'b0;
    ld_pick_s  = 1'b0;
    cu_pick_s  = 1'b0;
    starve_nxt = starve_r;
    case (state_r)
      ST_INIT: begin
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        run_s = 1'b1;
        if (ld_v_s && !(cu_v_s && (starve_r == CW'(STARVE_MAX)))) begin
          ld_pick_s = 1'b1;
        end else if (cu_v_s) begin
          cu_pick_s = 1'b1;
        end else begin
          ld_pick_s = 1'b0;
        end
        if (cu_pick_s) begin
          starve_nxt = '0;
        end else if (cu_v_s) begin
          starve_nxt = starve_r + CW'(1);
        end else begin
          starve_nxt = starve_r;
        end
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

  // Registered writeback port, status flags and starvation count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_sel_r    <= SEL_W'(WB_ZERO);
      wb_dst_r    <= '0;
      wb_we_r     <= 1'b0;
      init_done_r <= 1'b0;
      sel_err_r   <= 1'b0;
      pend_cnt_r  <= 2'd0;
      starve_r    <= '0;
    end else begin
      sel_err_r  <= bus.cu_valid && cu_ready_s && !cu_sel_legal(bus.cu_sel);
      pend_cnt_r <= {1'b0, cu_nxt_s} + {1'b0, ld_nxt_s};
      starve_r   <= starve_nxt;
      case (state_r)
        ST_INIT: begin
          init_done_r <= 1'b1;
          if (INIT_EN) begin
            wb_sel_r <= SEL_W'(WB_K227);
            wb_dst_r <= REG_AW'(INIT_REG);
            wb_we_r  <= 1'b1;
          end else begin
            wb_we_r  <= 1'b0;
          end
        end
        ST_RUN: begin
          // Destination 0 consumes the slot and moves the mux but never writes.
          if (ld_pick_s) begin
            {wb_sel_r, wb_dst_r} <= ld_q_s;
            wb_we_r <= (ld_q_s[REG_AW-1:0] != REG_AW'(0));
          end else if (cu_pick_s) begin
            {wb_sel_r, wb_dst_r} <= cu_q_s;
            wb_we_r <= (cu_q_s[REG_AW-1:0] != REG_AW'(0));
          end else begin
            wb_we_r <= 1'b0;
          end
        end
        default: begin
          wb_we_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cu_ready  = cu_ready_s;
  assign bus.ld_ready  = ld_ready_s;
  assign bus.wb_sel    = wb_sel_r;
  assign bus.wb_dst    = wb_dst_r;
  assign bus.wb_we     = wb_we_r;
  assign bus.init_done = init_done_r;
  assign bus.sel_err   = sel_err_r;
  assign bus.pend_cnt  = pend_cnt_r;
endmodule

// File: tb/tb_wb_sched.sv
// Directed bench for wb_sched; expected writes are queued at stimulus time and
// popped whenever the write port fires.
module tb_wb_sched;
  import wb_sched_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  int         tests = 0;
  int         fails = 0;
  logic [8:0] sb[$];

  wb_sched_if bus();

  wb_sched dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then check any write against the scoreboard head.
  task automatic step();
    logic [8:0] e;
    @(posedge clk);
    #1;
    if (bus.wb_we === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write_q", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("wr_sel", 32'(bus.wb_sel), 32'(e[8:5]));
        chk("wr_dst", 32'(bus.wb_dst), 32'(e[4:0]));
      end
    end
  endtask

  initial begin
    int n;
    logic acc;
    reset_n      = 1'b0;
    bus.cu_valid = 1'b0;
    bus.cu_sel   = 4'd0;
    bus.cu_dst   = 5'd0;
    bus.ld_valid = 1'b0;
    bus.ld_dst   = 5'd0;
    step();
    step();
    chk("rst_sel", 32'(bus.wb_sel), 32'h5);
    chk("rst_dst", 32'(bus.wb_dst), 32'd0);
    chk("rst_we", 32'(bus.wb_we), 32'd0);
    chk("rst_init_done", 32'(bus.init_done), 32'd0);
    chk("rst_sel_err", 32'(bus.sel_err), 32'd0);
    chk("rst_pend", 32'(bus.pend_cnt), 32'd0);

    // INIT write of 227 to r29, exactly once.
    sb.push_back({4'b0100, 5'd29});
    reset_n = 1'b1;
    #1;
    chk("init_cu_ready", 32'(bus.cu_ready), 32'd0);
    chk("init_ld_ready", 32'(bus.ld_ready), 32'd0);
    step();
    chk("init_we", 32'(bus.wb_we), 32'd1);
    chk("init_done", 32'(bus.init_done), 32'd1);
    step();
    chk("init_we_once", 32'(bus.wb_we), 32'd0);
    chk("init_sel_hold", 32'(bus.wb_sel), 32'h4);

    // Single control-unit request, two-edge latency, then select holds.
    bus.cu_valid = 1'b1; bus.cu_sel = 4'b0010; bus.cu_dst = 5'd8;
    sb.push_back({4'b0010, 5'd8});
    chk("cu_ready_run", 32'(bus.cu_ready), 32'd1);
    step();
    bus.cu_valid = 1'b0;
    chk("cu_lat_no_we", 32'(bus.wb_we), 32'd0);
    chk("cu_pend1", 32'(bus.pend_cnt), 32'd1);
    step();
    chk("cu_we", 32'(bus.wb_we), 32'd1);
    step();
    chk("idle_we", 32'(bus.wb_we), 32'd0);
    chk("idle_sel_hold", 32'(bus.wb_sel), 32'h2);
    chk("idle_dst_hold", 32'(bus.wb_dst), 32'd8);
    chk("idle_pend0", 32'(bus.pend_cnt), 32'd0);

    // Same destination from both: load first, control unit last.
    sb.push_back({4'b0001, 5'd5});
    sb.push_back({4'b0000, 5'd5});
    bus.cu_valid = 1'b1; bus.cu_sel = 4'b0000; bus.cu_dst = 5'd5;
    bus.ld_valid = 1'b1; bus.ld_dst = 5'd5;
    step();
    bus.cu_valid = 1'b0; bus.ld_valid = 1'b0;
    chk("both_pend2", 32'(bus.pend_cnt), 32'd2);
    step();
    chk("both_we_ld", 32'(bus.wb_we), 32'd1);
    chk("both_pend1", 32'(bus.pend_cnt), 32'd1);
    step();
    chk("both_we_cu", 32'(bus.wb_we), 32'd1);
    chk("both_pend0", 32'(bus.pend_cnt), 32'd0);
    step();
    chk("both_idle", 32'(bus.wb_we), 32'd0);

    // Continuous loads: control unit wins after exactly two load writes.
    sb.push_back({4'b0001, 5'd10});
    sb.push_back({4'b0001, 5'd11});
    sb.push_back({4'b0011, 5'd20});
    sb.push_back({4'b0001, 5'd12});
    sb.push_back({4'b0001, 5'd13});
    n = 10;
    bus.ld_valid = 1'b1; bus.ld_dst = 5'(n);
    bus.cu_valid = 1'b1; bus.cu_sel = 4'b0011; bus.cu_dst = 5'd20;
    chk("starve_cu_ready", 32'(bus.cu_ready), 32'd1);
    for (int c = 0; c < 20 && n < 14; c++) begin
      acc = bus.ld_ready;
      step();
      bus.cu_valid = 1'b0;
      if (acc) begin
        n++;
        bus.ld_dst = 5'(n);
      end
      if (n == 14) bus.ld_valid = 1'b0;
    end
    chk("starve_all_loads_sent", 32'(n), 32'd14);
    repeat (4) step();
    chk("starve_sb_empty", 32'(sb.size()), 32'd0);

    // Illegal selects: handshake, one sel_err pulse, no write.
    bus.cu_valid = 1'b1; bus.cu_sel = 4'b1011; bus.cu_dst = 5'd7;
    chk("ill_ready", 32'(bus.cu_ready), 32'd1);
    step();
    bus.cu_valid = 1'b0;
    chk("ill_err", 32'(bus.sel_err), 32'd1);
    chk("ill_pend", 32'(bus.pend_cnt), 32'd0);
    step();
    chk("ill_err_pulse", 32'(bus.sel_err), 32'd0);
    chk("ill_no_we", 32'(bus.wb_we), 32'd0);
    bus.cu_valid = 1'b1; bus.cu_sel = 4'b0001; bus.cu_dst = 5'd7;
    step();
    bus.cu_valid = 1'b0;
    chk("mdr_err", 32'(bus.sel_err), 32'd1);
    step();
    chk("mdr_no_we", 32'(bus.wb_we), 32'd0);

    // Destination 0: slot issues, mux moves, no write enable.
    bus.cu_valid = 1'b1; bus.cu_sel = 4'b0110; bus.cu_dst = 5'd0;
    step();
    bus.cu_valid = 1'b0;
    step();
    chk("dst0_we", 32'(bus.wb_we), 32'd0);
    chk("dst0_sel", 32'(bus.wb_sel), 32'h6);
    chk("dst0_dst", 32'(bus.wb_dst), 32'd0);
    chk("dst0_pend", 32'(bus.pend_cnt), 32'd0);

    // Reset with both buffers full: immediate return, INIT repeats, nothing stale.
    bus.cu_valid = 1'b1; bus.cu_sel = 4'b0111; bus.cu_dst = 5'd9;
    bus.ld_valid = 1'b1; bus.ld_dst = 5'd3;
    step();
    bus.cu_valid = 1'b0; bus.ld_valid = 1'b0;
    chk("full_pend2", 32'(bus.pend_cnt), 32'd2);
    reset_n = 1'b0;
    #1;
    chk("arst_sel", 32'(bus.wb_sel), 32'h5);
    chk("arst_dst", 32'(bus.wb_dst), 32'd0);
    chk("arst_we", 32'(bus.wb_we), 32'd0);
    chk("arst_pend", 32'(bus.pend_cnt), 32'd0);
    chk("arst_init_done", 32'(bus.init_done), 32'd0);
    step();
    sb.push_back({4'b0100, 5'd29});
    reset_n = 1'b1;
    step();
    chk("reinit_we", 32'(bus.wb_we), 32'd1);
    repeat (5) step();
    chk("reinit_sb_empty", 32'(sb.size()), 32'd0);
    chk("reinit_pend", 32'(bus.pend_cnt), 32'd0);
    chk("reinit_done", 32'(bus.init_done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
